// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the MIPS pipeline registers and the hazard unit.
//   - default widths for the pc8 and Tnew fields
//   - NOP_PAYLOAD: the all-zero payload loaded by a bubble (regwrite/memwrite=0)
//   - bit layout of the fields packed into the opaque stage payload
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int PC_W_DEF      = 32;
    localparam int TNEW_W_DEF    = 2;
    localparam int PAYLOAD_W_DEF = 128;

    // Widest payload any stage carries; NOP_PAYLOAD is sliced down per instance.
    localparam int PAYLOAD_MAX_W = 128;
    localparam logic [PAYLOAD_MAX_W-1:0] NOP_PAYLOAD = '0;

    // Payload layout (LSB offsets and widths).
    localparam int PL_CTRL_LSB = 0;    // control bits (regwrite, memwrite, ...)
    localparam int PL_CTRL_W   = 16;
    localparam int PL_A1_LSB   = 16;   // source register 1
    localparam int PL_A2_LSB   = 21;   // source register 2
    localparam int PL_A3_LSB   = 26;   // destination register
    localparam int PL_REG_W    = 5;
    localparam int PL_IMM_LSB  = 32;   // sign/zero-extended immediate
    localparam int PL_RD1_LSB  = 64;   // operand read from a1
    localparam int PL_RD2_LSB  = 96;   // operand read from a2
    localparam int PL_WORD_W   = 32;

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at its maximum value instead of wrapping.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset, forces cnt to 0
//   inc   : add one this edge (ignored at saturation)
//   clr   : synchronous clear, wins over inc
//   cnt   : current count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Generic inter-stage register of the five-stage MIPS core (D/E, E/M, M/W).
// Supports hold, bubble insertion, a valid bit, Tnew ageing and a stall
// performance counter.
//   clk, reset          : clock, asynchronous active-low reset
//   en, flush           : hazard-unit control (flush > load > hold)
//   in_valid/pc8/tnew/payload  : upstream stage slot
//   out_valid/pc8/tnew/payload : registered slot for the downstream stage
//   stall_cnt, clr_cnt  : saturating count of edges spent holding a valid slot,
//                         and its synchronous clear
// -----------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int PAYLOAD_W        = PAYLOAD_W_DEF,
    parameter int PC_W             = PC_W_DEF,
    parameter int TNEW_W           = TNEW_W_DEF,
    parameter bit TNEW_DEC         = 1'b1,
    parameter bit KEEP_PC_ON_FLUSH = 1'b1,
    parameter int CNT_W            = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [PC_W-1:0]      in_pc8,
    input  logic [TNEW_W-1:0]    in_tnew,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    output logic [PC_W-1:0]      out_pc8,
    output logic [TNEW_W-1:0]    out_tnew,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [CNT_W-1:0]     stall_cnt,
    input  logic                 clr_cnt
);

    // One stage closer to producing its result: decrement, but 0 stays 0.
    function automatic logic [TNEW_W-1:0] age_tnew(input logic [TNEW_W-1:0] t);
        if (TNEW_DEC && (t != '0)) begin
            return t - TNEW_W'(1);
        end
        return t;
    endfunction

    logic hold_valid;

    // Only edges that keep a real instruction in place count as stall cycles;
    // a flush edge never counts even with en=0.
    assign hold_valid = !flush && !en && out_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid   <= 1'b0;
            out_pc8     <= '0;
            out_tnew    <= '0;
            out_payload <= '0;
        end else if (flush) begin
            // Bubble: pc8 may be retained so exception/branch logic still
            // sees the address of the squashed slot.
            out_valid   <= 1'b0;
            out_pc8     <= KEEP_PC_ON_FLUSH ? in_pc8 : '0;
            out_tnew    <= '0;
            out_payload <= NOP_PAYLOAD[PAYLOAD_W-1:0];
        end else if (en) begin
            out_valid   <= in_valid;
            out_pc8     <= in_pc8;
            out_tnew    <= age_tnew(in_tnew);
            out_payload <= in_payload;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (hold_valid),
        .clr   (clr_cnt),
        .cnt   (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
// Two instances share one stimulus stream:
//   dut_a : PAYLOAD_W=128, TNEW_DEC=1, KEEP_PC_ON_FLUSH=1, CNT_W=16
//   dut_b : PAYLOAD_W=8,   TNEW_DEC=0, KEEP_PC_ON_FLUSH=0, CNT_W=3
// Expected slots are pushed to per-instance queues when inputs are driven and
// popped after the following rising edge.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    typedef struct {
        logic         v;
        logic [31:0]  pc;
        logic [1:0]   tn;
        logic [127:0] pl;
        logic [15:0]  cnt;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         en, flush, clr_cnt, in_valid;
    logic [31:0]  in_pc8;
    logic [1:0]   in_tnew;
    logic [127:0] in_payload;
    logic [7:0]   in_payload_b;

    logic         a_valid, b_valid;
    logic [31:0]  a_pc8, b_pc8;
    logic [1:0]   a_tnew, b_tnew;
    logic [127:0] a_payload;
    logic [7:0]   b_payload;
    logic [15:0]  a_cnt;
    logic [2:0]   b_cnt;

    int total = 0;
    int fails = 0;

    exp_t ma, mb;
    exp_t qa[$], qb[$];

    assign in_payload_b = in_payload[7:0];

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .PAYLOAD_W(128), .PC_W(32), .TNEW_W(2),
        .TNEW_DEC(1'b1), .KEEP_PC_ON_FLUSH(1'b1), .CNT_W(16)
    ) dut_a (
        .clk(clk), .reset(reset), .en(en), .flush(flush),
        .in_valid(in_valid), .in_pc8(in_pc8), .in_tnew(in_tnew),
        .in_payload(in_payload),
        .out_valid(a_valid), .out_pc8(a_pc8), .out_tnew(a_tnew),
        .out_payload(a_payload), .stall_cnt(a_cnt), .clr_cnt(clr_cnt)
    );

    pipe_stage_reg #(
        .PAYLOAD_W(8), .PC_W(32), .TNEW_W(2),
        .TNEW_DEC(1'b0), .KEEP_PC_ON_FLUSH(1'b0), .CNT_W(3)
    ) dut_b (
        .clk(clk), .reset(reset), .en(en), .flush(flush),
        .in_valid(in_valid), .in_pc8(in_pc8), .in_tnew(in_tnew),
        .in_payload(in_payload_b),
        .out_valid(b_valid), .out_pc8(b_pc8), .out_tnew(b_tnew),
        .out_payload(b_payload), .stall_cnt(b_cnt), .clr_cnt(clr_cnt)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        total++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference behaviour of one register instance for one edge.
    function automatic exp_t model(input exp_t cur, input bit dec, input bit keep,
                                   input logic [15:0] cmax, input logic [127:0] pmask);
        exp_t n = cur;
        if (flush) begin
            n.v  = 1'b0;
            n.pl = '0;
            n.tn = 2'd0;
            n.pc = keep ? in_pc8 : 32'd0;
        end else if (en) begin
            n.v  = in_valid;
            n.pc = in_pc8;
            n.pl = in_payload & pmask;
            n.tn = (dec && in_tnew != 2'd0) ? in_tnew - 2'd1 : in_tnew;
        end
        if (clr_cnt) n.cnt = 16'd0;
        else if (!flush && !en && cur.v && cur.cnt < cmax) n.cnt = cur.cnt + 16'd1;
        return n;
    endfunction

    task automatic compare_outputs();
        exp_t ea, eb;
        if (qa.size() == 0 || qb.size() == 0) begin
            check("scoreboard_empty", 128'(qa.size() + qb.size()), 128'd2);
            return;
        end
        ea = qa.pop_front();
        eb = qb.pop_front();
        check("a_valid",   128'(a_valid),   128'(ea.v));
        check("a_pc8",     128'(a_pc8),     128'(ea.pc));
        check("a_tnew",    128'(a_tnew),    128'(ea.tn));
        check("a_payload", a_payload,       ea.pl);
        check("a_cnt",     128'(a_cnt),     128'(ea.cnt));
        check("b_valid",   128'(b_valid),   128'(eb.v));
        check("b_pc8",     128'(b_pc8),     128'(eb.pc));
        check("b_tnew",    128'(b_tnew),    128'(eb.tn));
        check("b_payload", 128'(b_payload), eb.pl);
        check("b_cnt",     128'(b_cnt),     128'(eb.cnt));
    endtask

    // Drive one cycle of stimulus at the falling edge, record the expected
    // result, then compare just after the rising edge.
    task automatic step(input logic e, input logic f, input logic c, input logic v,
                        input logic [31:0] pc, input logic [1:0] tn, input logic [127:0] pl);
        @(negedge clk);
        en = e; flush = f; clr_cnt = c; in_valid = v;
        in_pc8 = pc; in_tnew = tn; in_payload = pl;
        ma = model(ma, 1'b1, 1'b1, 16'hFFFF, {128{1'b1}});
        mb = model(mb, 1'b0, 1'b0, 16'd7, 128'hFF);
        qa.push_back(ma);
        qb.push_back(mb);
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a_valid"},   128'(a_valid),   128'd0);
        check({tag, "_a_pc8"},     128'(a_pc8),     128'd0);
        check({tag, "_a_tnew"},    128'(a_tnew),    128'd0);
        check({tag, "_a_payload"}, a_payload,       128'd0);
        check({tag, "_a_cnt"},     128'(a_cnt),     128'd0);
        check({tag, "_b_payload"}, 128'(b_payload), 128'd0);
        check({tag, "_b_cnt"},     128'(b_cnt),     128'd0);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        ma = '{v: 1'b0, pc: 32'd0, tn: 2'd0, pl: 128'd0, cnt: 16'd0};
        mb = ma;
        reset = 1'b1;
        en = 1'b1; flush = 1'b0; clr_cnt = 1'b0; in_valid = 1'b1;
        in_pc8 = 32'h1234; in_tnew = 2'd3; in_payload = {128{1'b1}};

        // Load something non-zero so the reset check is meaningful.
        step(1, 0, 0, 1, 32'h1234, 2'd3, {128{1'b1}});
        step(0, 0, 0, 1, 32'h0, 2'd0, 128'd0);

        // Asynchronous reset mid-cycle, inputs all ones.
        @(negedge clk);
        #2;
        in_payload = {128{1'b1}}; en = 1'b1; in_valid = 1'b1;
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge clk);
        #1;
        check_all_zero("reset_held");
        ma = '{v: 1'b0, pc: 32'd0, tn: 2'd0, pl: 128'd0, cnt: 16'd0};
        mb = ma;
        @(negedge clk);
        reset = 1'b1;

        // First load after reset.
        step(1, 0, 0, 1, 32'h3008, 2'd2, 128'hA5A5_0000_1111_2222_3333_4444_5555_66C3);
        check("first_pc8",   128'(a_pc8),   128'h3008);
        check("first_tnew",  128'(a_tnew),  128'd1);
        check("first_valid", 128'(a_valid), 128'd1);
        check("first_tnew_nodec", 128'(b_tnew), 128'd2);

        // Tnew ageing limits.
        step(1, 0, 0, 1, 32'h300C, 2'd0, rnd128());
        check("tnew_zero_stays", 128'(a_tnew), 128'd0);
        step(1, 0, 0, 1, 32'h3010, 2'd3, rnd128());
        check("tnew_nodec_3", 128'(b_tnew), 128'd3);
        check("tnew_dec_3",   128'(a_tnew), 128'd2);

        // Stall: five holds with changing inputs, then clear during a hold.
        step(1, 0, 0, 1, 32'h4000, 2'd1, 128'hDEAD_BEEF);
        for (int i = 0; i < 5; i++) step(0, 0, 0, i[0], 32'h5000 + i, 2'(i), rnd128());
        check("stall_frozen_pc8", 128'(a_pc8), 128'h4000);
        check("stall_cnt_5a", 128'(a_cnt), 128'd5);
        check("stall_cnt_5b", 128'(b_cnt), 128'd5);
        step(0, 0, 1, 1, 32'h6000, 2'd2, rnd128());
        check("clr_wins", 128'(a_cnt), 128'd0);

        // Flush with en=0 inserts a bubble.
        step(0, 1, 0, 1, 32'h3010, 2'd3, {128{1'b1}});
        check("flush_valid",   128'(a_valid),   128'd0);
        check("flush_payload", a_payload,       128'd0);
        check("flush_tnew",    128'(a_tnew),    128'd0);
        check("flush_keep_pc", 128'(a_pc8),     128'h3010);
        check("flush_zero_pc", 128'(b_pc8),     128'd0);

        // Hold a bubble: no counting.
        step(0, 0, 0, 1, 32'h7000, 2'd1, rnd128());
        check("bubble_hold_cnt", 128'(a_cnt), 128'd0);

        // Counter saturation for CNT_W=3.
        step(1, 0, 0, 1, 32'h8000, 2'd1, rnd128());
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 32'h8100, 2'd2, rnd128());
        check("sat_cnt_b", 128'(b_cnt), 128'd7);
        check("sat_cnt_a", 128'(a_cnt), 128'd10);

        // Flush together with clear.
        step(0, 1, 1, 1, 32'h9000, 2'd2, rnd128());
        check("flush_clr_cnt", 128'(b_cnt), 128'd0);

        // Reset in the middle of a hold restarts the counter.
        step(1, 0, 0, 1, 32'hA000, 2'd2, rnd128());
        step(0, 0, 0, 1, 32'hA004, 2'd2, rnd128());
        step(0, 0, 0, 1, 32'hA008, 2'd2, rnd128());
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_all_zero("reset_mid_hold");
        ma = '{v: 1'b0, pc: 32'd0, tn: 2'd0, pl: 128'd0, cnt: 16'd0};
        mb = ma;
        @(negedge clk);
        reset = 1'b1;
        step(0, 0, 0, 1, 32'hB000, 2'd2, rnd128());

        // Random regression against the reference model.
        for (int i = 0; i < 10000; i++) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 19) == 0), 1'($urandom),
                 $urandom, 2'($urandom), rnd128());
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage MIPS core. It replaces the per-stage fixed registers (D/E, E/M, M/W) with one generic block. Added behaviour:
- stall (hold);
- flush (bubble insertion) with optional PC retention;
- a valid bit;
- saturating Tnew ageing;
- a saturating stall-cycle performance counter.

One instance sits between each pair of adjacent stages. The hazard unit drives `en`/`flush`.

## Interface
Parameters:
- PAYLOAD_W, 128, width of the opaque control+data payload (operands, ext imm, instr, a1/a2/a3, ctrl bits)
- PC_W, 32, width of the pc8 field
- TNEW_W, 2, width of the Tnew field
- TNEW_DEC, 1, 1 = Tnew decremented (saturating at 0) when loaded; 0 = passed unchanged
- KEEP_PC_ON_FLUSH, 1, 1 = flush keeps incoming pc8 in the bubble; 0 = bubble pc8 = 0
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low (0 = reset asserted)
- en  in  1  1 = advance (load inputs), 0 = hold
- flush  in  1  1 = load a bubble
- in_valid  in  1  upstream slot holds a real instruction
- in_pc8  in  PC_W  upstream pc8
- in_tnew  in  TNEW_W  upstream Tnew
- in_payload  in  PAYLOAD_W  upstream payload
- out_valid  out  1  registered valid
- out_pc8  out  PC_W  registered pc8
- out_tnew  out  TNEW_W  registered Tnew
- out_payload  out  PAYLOAD_W  registered payload
- stall_cnt  out  CNT_W  cycles spent holding a valid instruction, saturating
- clr_cnt  in  1  synchronous clear of stall_cnt

## Operation
- Reset (reset=0, asynchronous): every output is forced to 0 (out_valid, out_pc8, out_tnew, out_payload, stall_cnt), independent of clk. These values hold until the first rising edge after reset returns to 1.
- Priority per edge: flush > en=1 load > en=0 hold.
- Flush:
  - out_valid=0, out_payload=0 (NOP, regwrite/memwrite=0), out_tnew=0.
  - out_pc8 = in_pc8 if KEEP_PC_ON_FLUSH else 0.
  - Flush with en=0 still inserts the bubble. This is the stall-bubble case in D/E.
- Load (en=1, flush=0):
  - out_valid=in_valid, out_pc8=in_pc8, out_payload=in_payload.
  - out_tnew = (TNEW_DEC && in_tnew!=0) ? in_tnew-1 : in_tnew.
  - in_valid=0 loads a bubble verbatim; payload is not forced to 0.
- Hold (en=0, flush=0): all out_* unchanged.
- stall_cnt:
  - +1 on each edge taking the hold path while out_valid=1.
  - Saturates at 2^CNT_W-1; no wrap.
  - clr_cnt=1 sets it to 0 and has priority over increment.
  - stall_cnt is unaffected by flush.

## Timing
- Latency 1 cycle: inputs sampled at an edge appear on out_* after that edge. No combinational path from inputs to outputs.
- en/flush are sampled at the same edge as the data. Changes between edges have no effect.
- Reset deassertion is synchronised externally. The block only needs outputs stable at 0 while reset=0.
- Tnew arithmetic is unsigned TNEW_W bits; 0 stays 0 (no underflow to all-ones).
- Simultaneous cases:
  - flush+clr_cnt: both act.
  - hold at saturation: counter stays at max.
  - reset mid-hold: immediate clear; the counter restarts from 0.

## Structure
- Shared package pipe_pkg:
  - TNEW_W, PC_W defaults;
  - NOP_PAYLOAD constant (all zero);
  - the localparam layout (bit offsets) of the payload fields used by each stage.
  Every instance and the hazard unit import it.
- One sub-module, sat_counter (params W; ports clk, reset, inc, clr, cnt), instantiated for stall_cnt.
- Everything else is a single always block with asynchronous reset.

## Test plan
- Reset: drive reset=0 mid-cycle with in_payload=all ones -> all outputs 0 immediately, before the next edge. Release reset, apply en=1, in_valid=1, in_pc8=0x3008, in_tnew=2 -> after 1 edge out_pc8=0x3008, out_tnew=1, out_valid=1.
- Tnew saturation: load in_tnew=0 with TNEW_DEC=1 -> out_tnew=0. With TNEW_DEC=0, in_tnew=3 -> out_tnew=3.
- Stall: load a valid instr, then en=0 for 5 edges with changing inputs -> outputs frozen, stall_cnt=5. clr_cnt=1 for one edge -> 0.
- Flush priority: en=0, flush=1, in_pc8=0x3010 -> out_valid=0, out_payload=0, out_tnew=0, and out_pc8=0x3010 (KEEP_PC_ON_FLUSH=1) or 0 (KEEP_PC_ON_FLUSH=0).
- Counter saturation: CNT_W=3, hold valid for 10 edges -> stall_cnt=7. Hold with out_valid=0 -> no increment.
- Random regression: 10k cycles of random en/flush/clr_cnt/inputs checked against a reference model across PAYLOAD_W={8,128}.
